// File: rtl/dbg_probe_responder.sv
// dbg_probe_responder: answers GET/PUT/ITER/SCAN requests from a host debug
// port against a table of probe registers that the design can also write.
module dbg_probe_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [ID_W-1:0]               req_id,
    input  logic [DATA_W-1:0]             req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_status,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_W-1:0]             rsp_data,
    input  logic [NUM_ENTRIES-1:0]        hw_we,
    input  logic [NUM_ENTRIES*DATA_W-1:0] hw_wdata,
    output logic [NUM_ENTRIES*DATA_W-1:0] probe_q
);

    localparam int CUR_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    localparam logic [1:0] OP_GET  = 2'd0;
    localparam logic [1:0] OP_PUT  = 2'd1;
    localparam logic [1:0] OP_ITER = 2'd2;
    localparam logic [1:0] OP_SCAN = 2'd3;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_NULL   = 2'd1;
    localparam logic [1:0] ST_BAD_ID = 2'd2;

    localparam logic [ID_W:0]   NUM_ID  = (ID_W+1)'(NUM_ENTRIES);
    localparam logic [CUR_W-1:0] NUM_CUR = CUR_W'(NUM_ENTRIES);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [CUR_W-1:0]       cursor_reg, cursor_next;
    logic [1:0]             status_reg, status_next;
    logic [ID_W-1:0]        id_reg, id_next;
    logic [DATA_W-1:0]      data_reg, data_next;

    logic [DATA_W-1:0]      entry_reg  [NUM_ENTRIES];
    logic [DATA_W-1:0]      entry_next [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] entry_we;
    logic [NUM_ENTRIES-1:0] put_sel;

    logic                   accept;
    logic                   id_ok;
    logic                   scan_ok;
    logic [IDX_W-1:0]       req_idx;
    logic [IDX_W-1:0]       cur_idx;

    assign accept  = req_valid && (state_reg == IDLE);
    assign id_ok   = ({1'b0, req_id} < NUM_ID);
    assign scan_ok = (cursor_reg < NUM_CUR);
    assign req_idx = req_id[IDX_W-1:0];
    assign cur_idx = cursor_reg[IDX_W-1:0];

    assign req_ready  = (state_reg == IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_status = status_reg;
    assign rsp_id     = id_reg;
    assign rsp_data   = data_reg;

    // Decode which entry an accepted in-range PUT targets
    always_comb begin
        put_sel = '0;
        if (accept && (req_op == OP_PUT) && id_ok) begin
            put_sel[req_idx] = 1'b1;
        end
    end

    // Per-entry write merge: a PUT beats a same-edge design-side write
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign entry_we[gi]   = put_sel[gi] | hw_we[gi];
            assign entry_next[gi] = put_sel[gi] ? req_data
                                                : hw_wdata[gi*DATA_W +: DATA_W];
            assign probe_q[gi*DATA_W +: DATA_W] = entry_reg[gi];
        end
    endgenerate

    // Probe register table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (entry_we[i]) begin
                    entry_reg[i] <= entry_next[i];
                end
            end
        end
    end

    // FSM state, iterator cursor and registered response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cursor_reg <= NUM_CUR;
            status_reg <= ST_OK;
            id_reg     <= '0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cursor_reg <= cursor_next;
            status_reg <= status_next;
            id_reg     <= id_next;
            data_reg   <= data_next;
        end
    end

    // Next state and response computation; reads use pre-edge entry values
    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        status_next = status_reg;
        id_next     = id_reg;
        data_next   = data_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = RESP;
                    case (req_op)
                        OP_GET: begin
                            id_next     = req_id;
                            status_next = id_ok ? ST_OK : ST_BAD_ID;
                            data_next   = id_ok ? entry_reg[req_idx] : '0;
                        end
                        OP_PUT: begin
                            id_next     = req_id;
                            status_next = id_ok ? ST_OK : ST_BAD_ID;
                            data_next   = id_ok ? req_data : '0;
                        end
                        OP_ITER: begin
                            cursor_next = '0;
                            status_next = ST_OK;
                            id_next     = ID_W'(NUM_ENTRIES);
                            data_next   = DATA_W'(NUM_ENTRIES);
                        end
                        default: begin
                            if (scan_ok) begin
                                status_next = ST_OK;
                                id_next     = ID_W'(cursor_reg);
                                data_next   = entry_reg[cur_idx];
                                cursor_next = cursor_reg + CUR_W'(1);
                            end else begin
                                // Exhausted: cursor holds until the next ITER
                                status_next = ST_NULL;
                                id_next     = '0;
                                data_next   = '0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_probe_responder.sv
// Directed testbench for dbg_probe_responder (8 entries x 32 bits, 8-bit ids).
module tb_dbg_probe_responder;

    localparam int NE = 8;
    localparam int DW = 32;
    localparam int IW = 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [IW-1:0]     req_id;
    logic [DW-1:0]     req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic [NE-1:0]     hw_we;
    logic [NE*DW-1:0]  hw_wdata;
    logic [NE*DW-1:0]  probe_q;

    int vectors;
    int miscompares;

    dbg_probe_responder #(.NUM_ENTRIES(NE), .DATA_W(DW), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_id     (req_id),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .hw_we      (hw_we),
        .hw_wdata   (hw_wdata),
        .probe_q    (probe_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request/response transaction with optional same-edge hw writes
    task automatic xact(input logic [1:0] op, input logic [IW-1:0] id,
                        input logic [DW-1:0] data, input logic [NE-1:0] we,
                        input logic [NE*DW-1:0] wd, output logic [1:0] st,
                        output logic [IW-1:0] rid, output logic [DW-1:0] rdat);
        int n;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL xact_ready: req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_id    = id;
        req_data  = data;
        hw_we     = we;
        hw_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        hw_we     = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL xact_timeout: rsp_valid=%b want 1 within 20 cycles", rsp_valid);
        end
        st   = rsp_status;
        rid  = rsp_id;
        rdat = rsp_data;
        $display("xact op=%0d id=%0d data=%h -> status=%0d id=%0d data=%h",
                 op, id, data, st, rid, rdat);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        vectors++;
        if (rsp_status !== 2'd0 || rsp_id !== '0 || rsp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: st=%0d id=%0d data=%h want 0/0/0", rsp_status, rsp_id, rsp_data);
        end
        vectors++;
        if (probe_q !== '0) begin
            miscompares++;
            $display("FAIL reset_probe: probe_q=%h want 0", probe_q);
        end
    endtask

    task automatic test_get_put();
        logic [1:0] st; logic [IW-1:0] rid; logic [DW-1:0] rd;
        xact(2'd0, 8'd3, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rid !== 8'd3 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL get3_init: st=%0d id=%0d data=%h want 0/3/0", st, rid, rd);
        end
        xact(2'd1, 8'd3, 32'hA5A5_0001, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rid !== 8'd3 || rd !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL put3: st=%0d id=%0d data=%h want 0/3/a5a50001", st, rid, rd);
        end
        vectors++;
        if (probe_q[3*DW +: DW] !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL put3_probe: slice3=%h want a5a50001", probe_q[3*DW +: DW]);
        end
        xact(2'd0, 8'd3, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rd !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL get3_after: st=%0d data=%h want 0/a5a50001", st, rd);
        end
    endtask

    task automatic test_bad_id();
        logic [1:0] st; logic [IW-1:0] rid; logic [DW-1:0] rd;
        logic [NE*DW-1:0] exp_q;
        exp_q = '0;
        exp_q[3*DW +: DW] = 32'hA5A5_0001;
        xact(2'd0, 8'd8, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd2 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL get8_bad: st=%0d data=%h want 2/0", st, rd);
        end
        xact(2'd1, 8'd200, 32'hDEAD_BEEF, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd2 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL put200_bad: st=%0d data=%h want 2/0", st, rd);
        end
        vectors++;
        if (probe_q !== exp_q) begin
            miscompares++;
            $display("FAIL bad_noeffect: probe_q=%h want %h", probe_q, exp_q);
        end
    endtask

    task automatic test_scan();
        logic [1:0] st; logic [IW-1:0] rid; logic [DW-1:0] rd;
        xact(2'd3, 8'd0, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd1 || rid !== 8'd0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL scan_pre_iter: st=%0d id=%0d data=%h want 1/0/0", st, rid, rd);
        end
        // Load every entry with a distinct value from the design side
        @(negedge clk);
        hw_we = '1;
        for (int i = 0; i < NE; i++) hw_wdata[i*DW +: DW] = 32'hC000_0000 + i;
        @(negedge clk);
        hw_we = '0;
        vectors++;
        if (probe_q[5*DW +: DW] !== 32'hC000_0005) begin
            miscompares++;
            $display("FAIL hw_load: slice5=%h want c0000005", probe_q[5*DW +: DW]);
        end
        xact(2'd2, 8'd0, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rid !== 8'd8 || rd !== 32'd8) begin
            miscompares++;
            $display("FAIL iter: st=%0d id=%0d data=%h want 0/8/8", st, rid, rd);
        end
        for (int i = 0; i < NE; i++) begin
            xact(2'd3, 8'd0, '0, '0, '0, st, rid, rd);
            vectors++;
            if (st !== 2'd0 || rid !== i[IW-1:0] || rd !== 32'hC000_0000 + i) begin
                miscompares++;
                $display("FAIL scan_%0d: st=%0d id=%0d data=%h want 0/%0d/%h",
                         i, st, rid, rd, i, 32'hC000_0000 + i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            xact(2'd3, 8'd0, '0, '0, '0, st, rid, rd);
            vectors++;
            if (st !== 2'd1 || rid !== 8'd0 || rd !== 32'h0) begin
                miscompares++;
                $display("FAIL scan_exhausted_%0d: st=%0d id=%0d data=%h want 1/0/0", i, st, rid, rd);
            end
        end
    endtask

    task automatic test_collision();
        logic [1:0] st; logic [IW-1:0] rid; logic [DW-1:0] rd;
        logic [NE*DW-1:0] wd;
        wd = '0;
        wd[2*DW +: DW] = 32'h22;
        xact(2'd1, 8'd2, 32'h11, 8'b0000_0100, wd, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rd !== 32'h11 || probe_q[2*DW +: DW] !== 32'h11) begin
            miscompares++;
            $display("FAIL put_vs_hw: st=%0d data=%h slice2=%h want 0/11/11", st, rd, probe_q[2*DW +: DW]);
        end
        wd = '0;
        wd[1*DW +: DW] = 32'h33;
        xact(2'd0, 8'd1, '0, 8'b0000_0010, wd, st, rid, rd);
        vectors++;
        if (st !== 2'd0 || rd !== 32'hC000_0001) begin
            miscompares++;
            $display("FAIL get_vs_hw: st=%0d data=%h want 0/c0000001", st, rd);
        end
        xact(2'd0, 8'd1, '0, '0, '0, st, rid, rd);
        vectors++;
        if (rd !== 32'h33) begin
            miscompares++;
            $display("FAIL get_after_hw: data=%h want 33", rd);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_id    = 8'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_status !== 2'd0 ||
                rsp_id !== 8'd5 || rsp_data !== 32'hC000_0005) begin
                miscompares++;
                $display("FAIL hold_%0d: v=%b rdy=%b st=%0d id=%0d data=%h want 1/0/0/5/c0000005",
                         c, rsp_valid, req_ready, rsp_status, rsp_id, rsp_data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("backpressure release: valid=%b ready=%b", rsp_valid, req_ready);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] st; logic [IW-1:0] rid; logic [DW-1:0] rd;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_id    = 8'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: rsp_valid=%b want 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || probe_q !== '0) begin
            miscompares++;
            $display("FAIL mid_async: valid=%b ready=%b probe_zero=%b want 0/1/1",
                     rsp_valid, req_ready, (probe_q == '0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (probe_q !== '0 || rsp_data !== '0) begin
            miscompares++;
            $display("FAIL mid_after: probe_q=%h data=%h want 0/0", probe_q, rsp_data);
        end
        xact(2'd3, 8'd0, '0, '0, '0, st, rid, rd);
        vectors++;
        if (st !== 2'd1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_scan: st=%0d data=%h want 1/0", st, rd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'd0;
        req_id      = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        hw_we       = '0;
        hw_wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_get_put();
        test_bad_id();
        test_scan();
        test_collision();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbg_probe_responder.md
# dbg_probe_responder

Synthesizable responder for the introspection protocol: a host-side initiator issues get, put, iterate and scan requests, and this block answers them. It owns a table of NUM_ENTRIES probe registers that the surrounding design can also update. It sits between the host debug port and the DUT, and gives hardware the same handle-by-index read/write and iterator/scan semantics that VPI provides in simulation.

## Interface
- NUM_ENTRIES, 8: number of probe registers (1..255).
- DATA_W, 32: probe register width.
- ID_W, 8: width of request and response ids.

- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_op  in  2  request opcode: 0 GET, 1 PUT, 2 ITER, 3 SCAN.
- req_id  in  ID_W  entry index for GET and PUT; ignored for ITER and SCAN.
- req_data  in  DATA_W  write data for PUT.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_status  out  2  0 OK, 1 NULL (iterator exhausted), 2 BAD_ID.
- rsp_id  out  ID_W  entry index or count.
- rsp_data  out  DATA_W  read data.
- hw_we  in  NUM_ENTRIES  per-entry write strobe from the design side.
- hw_wdata  in  NUM_ENTRIES*DATA_W  per-entry design-side write data.
- probe_q  out  NUM_ENTRIES*DATA_W  current value of every entry.

## Operation
- FSM has two states, IDLE and RESP.
  - req_ready=1 only in IDLE.
  - A request is accepted when req_valid && req_ready; the FSM then moves to RESP.
  - RESP holds rsp_* stable with rsp_valid=1 until rsp_ready; it returns to IDLE on that edge.
- GET:
  - If req_id < NUM_ENTRIES: status OK, rsp_id=req_id, rsp_data = entry value sampled before this edge's writes.
  - Otherwise: status BAD_ID, rsp_data=0.
- PUT:
  - If req_id < NUM_ENTRIES: the entry is written on the accept edge; status OK, rsp_data = new value.
  - Otherwise: no write, status BAD_ID, rsp_data=0.
- ITER:
  - Sets cursor=0.
  - Response is status OK, rsp_id=NUM_ENTRIES, rsp_data=NUM_ENTRIES (zero-extended).
- SCAN:
  - If cursor < NUM_ENTRIES: status OK, rsp_id=cursor, rsp_data=entry[cursor]; cursor increments.
  - Otherwise: status NULL, rsp_id=0, rsp_data=0; cursor holds, so every further SCAN returns NULL until the next ITER.
- cursor is $clog2(NUM_ENTRIES+1) bits wide. It resets to NUM_ENTRIES, so a SCAN before any ITER returns NULL.
- Design-side writes: hw_we[i] loads entry i from hw_wdata slice i on any cycle, in any FSM state.
- Collision: a PUT accepted on the same edge as hw_we to the same entry; the PUT wins.
- A GET or SCAN colliding with hw_we returns the pre-edge value. The hw write still lands.
- Entries update only through PUT and hw_we; pending responses never change.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE, req_ready=1, rsp_valid=0.
  - rsp_status=0, rsp_id=0, rsp_data=0.
  - All entries=0, so probe_q=0; cursor=NUM_ENTRIES.
- Latency: with the accept edge at T, rsp_valid=1 in the cycle after T; all rsp_* are registered.
- Throughput: at most one transaction every 2 cycles, since req_ready=0 throughout RESP.
- Backpressure: rsp_* must be stable while rsp_valid && !rsp_ready.
- probe_q reflects a write on the cycle after the writing edge.
- Reset asserted mid-transaction: the response is dropped and all state returns to reset values immediately.

## Test plan
- Reset, then GET id 3 -> OK, data 0. PUT id 3 = 0xA5A5_0001 -> OK, data 0xA5A5_0001; probe_q slice 3 = 0xA5A5_0001. GET id 3 -> 0xA5A5_0001.
- GET id 8 and PUT id 200 with NUM_ENTRIES=8 -> BAD_ID, data 0; no entry changes.
- SCAN before any ITER -> NULL. Then ITER -> OK, id 8, data 8. Then 8 SCANs -> ids 0..7 with the entry values. The 9th and 10th SCAN -> NULL.
- PUT id 2 = 0x11 on the same edge as hw_we[2] with data 0x22 -> entry 2 = 0x11. GET id 1 on the same edge as hw_we[1] with data 0x33 -> returns the old value; a later GET -> 0x33.
- Hold rsp_ready=0 for 5 cycles after a GET -> rsp_* stable, req_ready=0; handshake on cycle 6 -> req_ready=1 the next cycle.
- Pull rst_n low while in RESP -> rsp_valid=0 immediately. After release, all probe_q=0 and SCAN -> NULL.
